// File: rtl/opnd_fetch_pkg.sv
// Shared types and constants for the operand-fetch stage.
// Holds the default widths, the output-stage state enum and the zero-register address.
// Optional feature macro used by importers: OPND_ZERO_REG_EN (register 0 hard-wired to zero).
package opnd_fetch_pkg;

  localparam int AW_DEF    = 7;
  localparam int DW_DEF    = 16;
  localparam int TAG_W_DEF = 4;

  // Address of the register that reads as zero when OPND_ZERO_REG_EN is defined.
  localparam int ADDR_ZERO = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // nothing to present
    ST_LIVE  = 2'd1,  // operands come straight from rf_rdata (plus bypass) this cycle
    ST_HELD  = 2'd2   // operands come from the hold registers
  } state_t;

endpackage

// File: rtl/opnd_bypass_cmp.sv
// Write-back bypass compare for one read port: flags a same-cycle write to the read address.
// Latency: purely combinational. Backpressure: none, evaluated every cycle.
// Ports: rd_addr (read address), wb_valid/wb_addr (write-back port), hit (bypass wb_data),
//        rd_zero (read must return zero; always 0 unless OPND_ZERO_REG_EN is defined).
module opnd_bypass_cmp
  import opnd_fetch_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic [AW-1:0] rd_addr,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  output logic          hit,
  output logic          rd_zero
);

  logic addr_eq;

  assign addr_eq = (wb_addr == rd_addr);

`ifdef OPND_ZERO_REG_EN
  // Register 0 never takes writes, so it can never be a bypass source.
  assign rd_zero = (rd_addr == AW'(ADDR_ZERO));
  assign hit     = wb_valid && addr_eq && !rd_zero;
`else
  assign rd_zero = 1'b0;
  assign hit     = wb_valid && addr_eq;
`endif

endmodule

// File: rtl/opnd_fetch.sv
// Operand fetch in front of a 2R1W register file built from registered-output SRAM macros.
// Latency: request accepted in cycle N presents operands in N+1; one request per cycle.
// Backpressure: req_ready = output empty || opnd_ready; a stalled result parks in a 1-entry hold buffer.
// Ports: req_* operand request (valid/ready), wb_* write-back (always accepted),
//        rf_* register-file macro ports, opnd_* result (valid/ready) with the request tag.
// Optional macro: OPND_ZERO_REG_EN makes register 0 read as zero and drops writes to it.
module opnd_fetch
  import opnd_fetch_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_addr_a,
  input  logic [AW-1:0]    req_addr_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_addr,
  input  logic [DW-1:0]    wb_data,
  output logic [AW-1:0]    rf_addr_a,
  output logic [AW-1:0]    rf_addr_b,
  output logic [AW-1:0]    rf_addr_c,
  output logic [DW-1:0]    rf_wdata,
  output logic             rf_we,
  input  logic [DW-1:0]    rf_rdata_a,
  input  logic [DW-1:0]    rf_rdata_b,
  output logic             opnd_valid,
  input  logic             opnd_ready,
  output logic [DW-1:0]    opnd_a,
  output logic [DW-1:0]    opnd_b,
  output logic [TAG_W-1:0] opnd_tag
);

  state_t           state, state_nxt;
  logic             accept;
  logic             hit_a_d, hit_b_d, zero_a_d, zero_b_d;
  logic             byp_hit_a, byp_hit_b, zero_a, zero_b;
  logic [DW-1:0]    byp_data;
  logic [DW-1:0]    live_a, live_b;
  logic [DW-1:0]    hold_a, hold_b;
  logic [TAG_W-1:0] tag_q;

  // The macros register the address themselves; we only steer their ports.
  assign rf_addr_a = req_addr_a;
  assign rf_addr_b = req_addr_b;
  assign rf_addr_c = wb_addr;
  assign rf_wdata  = wb_data;

`ifdef OPND_ZERO_REG_EN
  assign rf_we = wb_valid && (wb_addr != AW'(ADDR_ZERO));
`else
  assign rf_we = wb_valid;
`endif

  opnd_bypass_cmp #(.AW(AW)) u_cmp_a (
    .rd_addr  (req_addr_a),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .hit      (hit_a_d),
    .rd_zero  (zero_a_d)
  );

  opnd_bypass_cmp #(.AW(AW)) u_cmp_b (
    .rd_addr  (req_addr_b),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .hit      (hit_b_d),
    .rd_zero  (zero_b_d)
  );

  // A write landing on the same edge as the read address makes the SRAM output
  // undefined, so the write data captured at accept replaces rf_rdata in that case.
  assign live_a = zero_a ? '0 : (byp_hit_a ? byp_data : rf_rdata_a);
  assign live_b = zero_b ? '0 : (byp_hit_b ? byp_data : rf_rdata_b);

  assign opnd_tag = tag_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = (state == ST_EMPTY) || opnd_ready;
    accept     = req_valid && req_ready;
    opnd_valid = (state != ST_EMPTY);
    opnd_a     = hold_a;
    opnd_b     = hold_b;
    case (state)
      ST_EMPTY: begin
        if (accept) state_nxt = ST_LIVE;
      end
      ST_LIVE: begin
        opnd_a = live_a;
        opnd_b = live_b;
        if (accept)           state_nxt = ST_LIVE;
        else if (!opnd_ready) state_nxt = ST_HELD;
        else                  state_nxt = ST_EMPTY;
      end
      ST_HELD: begin
        // Accepting here implies opnd_ready, so the held entry leaves this cycle.
        if (accept)          state_nxt = ST_LIVE;
        else if (opnd_ready) state_nxt = ST_EMPTY;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byp_hit_a <= 1'b0;
      byp_hit_b <= 1'b0;
      zero_a    <= 1'b0;
      zero_b    <= 1'b0;
      byp_data  <= '0;
      tag_q     <= '0;
      hold_a    <= '0;
      hold_b    <= '0;
    end else begin
      if (accept) begin
        byp_hit_a <= hit_a_d;
        byp_hit_b <= hit_b_d;
        zero_a    <= zero_a_d;
        zero_b    <= zero_b_d;
        byp_data  <= wb_data;
        tag_q     <= req_tag;
      end
      // rf_rdata moves on next cycle, so a stalled live result must be parked now.
      if (state == ST_LIVE && !opnd_ready) begin
        hold_a <= live_a;
        hold_b <= live_b;
      end
    end
  end

endmodule
